operand_issue_stage: RTL and testbench
======================================

// Module: operand_issue_stage
// PURPOSE
//  Decode->execute issue stage. Drives regfile read addresses, collects RD1/RD2, resolves RAW
//  hazards (forwarding from EX/MEM and MEM/WB, load-use stall) and holds the ID/EX pipeline
//  register under a valid/ready handshake.
//  Sits between the decoder and the ALU stage of cpu_pipelined.
// PARAMETERS
//  SIZE        32  datapath width
//  AMOUNT_REG  4   register address width; address 4'b1111 is R15 (PC, supplied by regfile)
//  CTRL_W      12  width of opaque execute-control bundle passed through
// PORTS
//  CLK          in   1         clock, rising edge
//  RST_N        in   1         asynchronous active-low reset
//  in_valid     in   1         decoded instruction present
//  in_ready     out  1         stage accepts instruction this cycle
//  in_ra1/2     in   AMOUNT_REG source register addresses
//  in_use1/2    in   1         source actually read (0 = immediate/unused)
//  in_rd        in   AMOUNT_REG destination register
//  in_we        in   1         instruction writes in_rd
//  in_is_load   in   1         instruction is a load (result available only after MEM)
//  in_imm       in   SIZE      extended immediate
//  in_ctrl      in   CTRL_W    execute controls
//  RA1/RA2      out  AMOUNT_REG to regfile; combinational copy of in_ra1/in_ra2
//  RD1/RD2      in   SIZE      from regfile (R15 already substituted)
//  exm_rd/_we/_res in AMOUNT_REG/1/SIZE  EX/MEM destination, write enable, result
//  mwb_rd/_we/_res in AMOUNT_REG/1/SIZE  MEM/WB destination, write enable, writeback value
//  flush        in   1         branch taken; kill in-flight issue
//  out_valid    out  1         ID/EX register holds a valid instruction
//  out_ready    in   1         execute stage accepts
//  out_op1/op2  out  SIZE      resolved operands
//  out_rd/we/is_load/imm/ctrl  out  registered copies of inputs
// BEHAVIOUR
//  Reset (async, RST_N=0): out_valid=0, all out_* data = 0, FSM=RUN; in_ready=0 while in reset.
//  Advance: ID/EX loads when adv = !out_valid | out_ready. Transfer in = in_valid & in_ready.
//  in_ready = adv & !hazard_stall | flush.
//  Load-use hazard: out_valid & out_is_load & out_we & (in_use1 & in_ra1==out_rd |
//    in_use2 & in_ra2==out_rd), source != R15. Then in_ready=0; on adv the register loads a
//    bubble (out_valid=0); FSM RUN->LU_STALL for exactly one cycle, then RUN re-evaluates.
//  Forward per operand (priority): R15 -> RD (never forwarded); exm_we & exm_rd==ra -> exm_res;
//    mwb_we & mwb_rd==ra -> mwb_res (covers same-cycle regfile write); else RD.
//  Latency: 1 cycle in->out when unstalled; throughput 1/cycle.
//  Backpressure: out_ready=0 with out_valid=1 holds every out_* stable; in_ready=0.
//  Flush: next edge out_valid=0, FSM->RUN; input consumed and discarded (in_ready=1).
//    Flush beats stall and backpressure.
//  Simultaneous flush & out_ready=0: register still cleared (killed instruction dropped).
//  Reset mid-stall: returns to RUN, no bubble state retained.
//  FSM: RUN --(load-use & adv)--> LU_STALL --> RUN; any --flush--> RUN.
// CONFIGURATION
//  OPERAND_FWD_EN defined: forwarding muxes as above.
//  Undefined: no forwarding. Any RAW match vs. out_rd(out_we), exm_rd(exm_we) or mwb_rd(mwb_we)
//    stalls like load-use (bubble inserted); operands always from RD1/RD2.
// STRUCTURE
//  cpu_pkg: fwd_sel_e {FWD_RF, FWD_EXMEM, FWD_MEMWB}; issue_state_e {RUN, LU_STALL};
//    localparam R15_ADDR; CTRL_W default.
//  Sub-module operand_fwd_mux (hazard compare + 3:1 select), instantiated once per operand.
// TESTING
//  1 No hazard: ADD r1,r2,r3 with RD1=5, RD2=7 -> next cycle out_valid=1, op1=5, op2=7.
//  2 EX/MEM fwd: exm_rd=2, exm_we=1, exm_res=0xAA, RD1=5 on ra1=2 -> op1=0xAA.
//    Add mwb_rd=2, mwb_res=0xBB -> op1=0xAA (priority).
//  3 Load-use: LDR r4 in ID/EX, next instr reads r4 -> in_ready=0 one cycle, bubble out,
//    then issue with op from mwb/exm fwd.
//  4 R15 source with exm_rd=15, exm_we=1 -> op equals RD (PC), no forward.
//  5 out_ready=0 for 3 cycles -> out_* stable, in_ready=0; flush then -> out_valid=0 next edge.
//  6 RST_N low mid LU_STALL -> out_valid=0 immediately; without OPERAND_FWD_EN case 2 stalls
//    until exm/mwb clear.

Source files
------------

// File: rtl/operand_issue_stage_pkg.sv
// Shared types and constants for the operand issue stage.
package operand_issue_stage_pkg;

  localparam int unsigned SIZE_DEF       = 32;
  localparam int unsigned AMOUNT_REG_DEF = 4;
  localparam int unsigned CTRL_W_DEF     = 12;
  localparam logic [3:0]  R15_ADDR       = 4'hF;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } issue_state_e;

endpackage

// File: rtl/operand_issue_stage_fwd_mux.sv
// Per-operand RAW compare against in-flight producers and 3:1 operand select.
// FWD_EN=0 keeps the regfile value and reports any RAW match as a stall.
module operand_fwd_mux
  import operand_issue_stage_pkg::*;
#(
  parameter int unsigned SIZE       = SIZE_DEF,
  parameter int unsigned AMOUNT_REG = AMOUNT_REG_DEF,
  parameter bit          FWD_EN     = 1'b1
) (
  input  logic [AMOUNT_REG-1:0] ra_i,
  input  logic                  use_i,
  input  logic [SIZE-1:0]       rf_val_i,
  input  logic                  idex_valid_i,
  input  logic [AMOUNT_REG-1:0] idex_rd_i,
  input  logic                  idex_we_i,
  input  logic                  idex_load_i,
  input  logic [AMOUNT_REG-1:0] exm_rd_i,
  input  logic                  exm_we_i,
  input  logic [SIZE-1:0]       exm_res_i,
  input  logic [AMOUNT_REG-1:0] mwb_rd_i,
  input  logic                  mwb_we_i,
  input  logic [SIZE-1:0]       mwb_res_i,
  output logic [SIZE-1:0]       op_o,
  output logic                  stall_o
);

  logic     is_r15_s;
  logic     exm_match_s;
  logic     mwb_match_s;
  logic     hit_idex_s;
  logic     hit_exm_s;
  logic     hit_mwb_s;
  fwd_sel_e sel_s;

  always_comb begin
    is_r15_s    = (ra_i == AMOUNT_REG'(R15_ADDR));
    exm_match_s = exm_we_i && (exm_rd_i == ra_i);
    mwb_match_s = mwb_we_i && (mwb_rd_i == ra_i);
    hit_idex_s  = use_i && !is_r15_s && idex_valid_i && idex_we_i && (idex_rd_i == ra_i);
    hit_exm_s   = use_i && !is_r15_s && exm_match_s;
    hit_mwb_s   = use_i && !is_r15_s && mwb_match_s;

    // The PC is substituted by the regfile and is never a forwarding target.
    if (!FWD_EN || is_r15_s) begin
      sel_s = FWD_RF;
    end else if (exm_match_s) begin
      sel_s = FWD_EXMEM;
    end else if (mwb_match_s) begin
      sel_s = FWD_MEMWB;
    end else begin
      sel_s = FWD_RF;
    end

    case (sel_s)
      FWD_EXMEM: op_o = exm_res_i;
      FWD_MEMWB: op_o = mwb_res_i;
      FWD_RF:    op_o = rf_val_i;
      default:   op_o = rf_val_i;
    endcase

    if (FWD_EN) begin
      stall_o = hit_idex_s && idex_load_i;
    end else begin
      stall_o = hit_idex_s || hit_exm_s || hit_mwb_s;
    end
  end

endmodule

// File: rtl/operand_issue_stage.sv
// Decode->execute issue stage: operand fetch, RAW resolution and the ID/EX register.
// Define OPERAND_FWD_EN to enable EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall.
module operand_issue_stage
  import operand_issue_stage_pkg::*;
#(
  parameter int unsigned SIZE       = SIZE_DEF,
  parameter int unsigned AMOUNT_REG = AMOUNT_REG_DEF,
  parameter int unsigned CTRL_W     = CTRL_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AMOUNT_REG-1:0] in_ra1,
  input  logic [AMOUNT_REG-1:0] in_ra2,
  input  logic                  in_use1,
  input  logic                  in_use2,
  input  logic [AMOUNT_REG-1:0] in_rd,
  input  logic                  in_we,
  input  logic                  in_is_load,
  input  logic [SIZE-1:0]       in_imm,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic [AMOUNT_REG-1:0] RA1,
  output logic [AMOUNT_REG-1:0] RA2,
  input  logic [SIZE-1:0]       RD1,
  input  logic [SIZE-1:0]       RD2,
  input  logic [AMOUNT_REG-1:0] exm_rd,
  input  logic                  exm_we,
  input  logic [SIZE-1:0]       exm_res,
  input  logic [AMOUNT_REG-1:0] mwb_rd,
  input  logic                  mwb_we,
  input  logic [SIZE-1:0]       mwb_res,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE-1:0]       out_op1,
  output logic [SIZE-1:0]       out_op2,
  output logic [AMOUNT_REG-1:0] out_rd,
  output logic                  out_we,
  output logic                  out_is_load,
  output logic [SIZE-1:0]       out_imm,
  output logic [CTRL_W-1:0]     out_ctrl
);

`ifdef OPERAND_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  issue_state_e          state_q, state_d;
  logic                  valid_q, valid_d;
  logic [SIZE-1:0]       op1_q, op1_d, op2_q, op2_d;
  logic [AMOUNT_REG-1:0] rd_q, rd_d;
  logic                  we_q, we_d, load_q, load_d;
  logic [SIZE-1:0]       imm_q, imm_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;

  logic [SIZE-1:0] fwd_op1_s, fwd_op2_s;
  logic            stall1_s, stall2_s;
  logic            adv_s, hazard_s, ready_s, xfer_s;

  assign RA1 = in_ra1;
  assign RA2 = in_ra2;

  operand_fwd_mux #(.SIZE(SIZE), .AMOUNT_REG(AMOUNT_REG), .FWD_EN(FWD_EN)) u_fwd1 (
    .ra_i(in_ra1), .use_i(in_use1), .rf_val_i(RD1),
    .idex_valid_i(valid_q), .idex_rd_i(rd_q), .idex_we_i(we_q), .idex_load_i(load_q),
    .exm_rd_i(exm_rd), .exm_we_i(exm_we), .exm_res_i(exm_res),
    .mwb_rd_i(mwb_rd), .mwb_we_i(mwb_we), .mwb_res_i(mwb_res),
    .op_o(fwd_op1_s), .stall_o(stall1_s)
  );

  operand_fwd_mux #(.SIZE(SIZE), .AMOUNT_REG(AMOUNT_REG), .FWD_EN(FWD_EN)) u_fwd2 (
    .ra_i(in_ra2), .use_i(in_use2), .rf_val_i(RD2),
    .idex_valid_i(valid_q), .idex_rd_i(rd_q), .idex_we_i(we_q), .idex_load_i(load_q),
    .exm_rd_i(exm_rd), .exm_we_i(exm_we), .exm_res_i(exm_res),
    .mwb_rd_i(mwb_rd), .mwb_we_i(mwb_we), .mwb_res_i(mwb_res),
    .op_o(fwd_op2_s), .stall_o(stall2_s)
  );

  always_comb begin
    adv_s    = !valid_q || out_ready;
    hazard_s = stall1_s || stall2_s;
    // Flush always consumes the input so the decoder can drop the killed instruction.
    ready_s  = RST_N && ((adv_s && !hazard_s) || flush);
    xfer_s   = in_valid && ready_s;

    state_d = state_q;
    valid_d = valid_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rd_d    = rd_q;
    we_d    = we_q;
    load_d  = load_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;

    case (state_q)
      RUN: begin
        if (!flush && adv_s && in_valid && hazard_s) begin
          state_d = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
      LU_STALL: state_d = RUN;
      default:  state_d = RUN;
    endcase

    if (flush) begin
      valid_d = 1'b0;
    end else if (adv_s) begin
      valid_d = xfer_s;
      if (xfer_s) begin
        op1_d  = fwd_op1_s;
        op2_d  = fwd_op2_s;
        rd_d   = in_rd;
        we_d   = in_we;
        load_d = in_is_load;
        imm_d  = in_imm;
        ctrl_d = in_ctrl;
      end else begin
        op1_d = op1_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      imm_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      load_q  <= load_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign in_ready    = ready_s;
  assign out_valid   = valid_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_rd      = rd_q;
  assign out_we      = we_q;
  assign out_is_load = load_q;
  assign out_imm     = imm_q;
  assign out_ctrl    = ctrl_q;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Randomized bench for operand_issue_stage against a rule-level reference model.
// Follows the OPERAND_FWD_EN setting of the build.
module tb_operand_issue_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid, in_ready;
  logic [3:0]  in_ra1, in_ra2, in_rd;
  logic        in_use1, in_use2, in_we, in_is_load;
  logic [31:0] in_imm;
  logic [11:0] in_ctrl;
  logic [3:0]  RA1, RA2;
  logic [31:0] RD1, RD2;
  logic [3:0]  exm_rd, mwb_rd;
  logic        exm_we, mwb_we;
  logic [31:0] exm_res, mwb_res;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2, out_imm;
  logic [3:0]  out_rd;
  logic        out_we, out_is_load;
  logic [11:0] out_ctrl;

  always #5 CLK = ~CLK;

  operand_issue_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra1(in_ra1), .in_ra2(in_ra2), .in_use1(in_use1), .in_use2(in_use2),
    .in_rd(in_rd), .in_we(in_we), .in_is_load(in_is_load),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .exm_rd(exm_rd), .exm_we(exm_we), .exm_res(exm_res),
    .mwb_rd(mwb_rd), .mwb_we(mwb_we), .mwb_res(mwb_res),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_we(out_we),
    .out_is_load(out_is_load), .out_imm(out_imm), .out_ctrl(out_ctrl)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  rd;
    logic        we;
    logic        ld;
    logic [31:0] imm;
    logic [11:0] ctrl;
  } stage_t;

  stage_t m;
  int     n_cmp = 0;
  int     n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Value the operand should carry: PC is never forwarded, youngest producer wins.
  function automatic logic [31:0] resolve(input logic [3:0] ra, input logic [31:0] rf);
`ifdef OPERAND_FWD_EN
    if (ra == 4'd15) return rf;
    if (exm_we && exm_rd == ra) return exm_res;
    if (mwb_we && mwb_rd == ra) return mwb_res;
`endif
    return rf;
  endfunction

  function automatic bit depends(input logic [3:0] ra, input logic use_src);
    if (!use_src || ra == 4'd15) return 1'b0;
`ifdef OPERAND_FWD_EN
    return m.v && m.ld && m.we && (m.rd == ra);
`else
    return (m.v && m.we && m.rd == ra) || (exm_we && exm_rd == ra) || (mwb_we && mwb_rd == ra);
`endif
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    bit     adv, haz, rdy;
    stage_t nxt;
    #1;
    adv = !m.v || out_ready;
    haz = depends(in_ra1, in_use1) || depends(in_ra2, in_use2);
    rdy = (adv && !haz) || flush;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    chk("RA1", {28'd0, RA1}, {28'd0, in_ra1});
    chk("RA2", {28'd0, RA2}, {28'd0, in_ra2});
    nxt = m;
    if (flush) begin
      nxt.v = 1'b0;
    end else if (adv) begin
      if (in_valid && rdy) begin
        nxt.v    = 1'b1;
        nxt.op1  = resolve(in_ra1, RD1);
        nxt.op2  = resolve(in_ra2, RD2);
        nxt.rd   = in_rd;
        nxt.we   = in_we;
        nxt.ld   = in_is_load;
        nxt.imm  = in_imm;
        nxt.ctrl = in_ctrl;
      end else begin
        nxt.v = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    m = nxt;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m.v});
    if (m.v) begin
      chk("out_op1", out_op1, m.op1);
      chk("out_op2", out_op2, m.op2);
      chk("out_rd", {28'd0, out_rd}, {28'd0, m.rd});
      chk("out_we", {31'd0, out_we}, {31'd0, m.we});
      chk("out_is_load", {31'd0, out_is_load}, {31'd0, m.ld});
      chk("out_imm", out_imm, m.imm);
      chk("out_ctrl", {20'd0, out_ctrl}, {20'd0, m.ctrl});
    end
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_ra1 = 4'd0; in_ra2 = 4'd0; in_use1 = 1'b0; in_use2 = 1'b0;
    in_rd = 4'd0; in_we = 1'b0; in_is_load = 1'b0; in_imm = 32'd0; in_ctrl = 12'd0;
    RD1 = 32'd0; RD2 = 32'd0; exm_rd = 4'd0; exm_we = 1'b0; exm_res = 32'd0;
    mwb_rd = 4'd0; mwb_we = 1'b0; mwb_res = 32'd0; flush = 1'b0; out_ready = 1'b1;
  endtask

  function automatic logic [3:0] pick_reg();
    if ($urandom_range(0, 7) == 0) return 4'd15;
    return 4'($urandom_range(1, 4));
  endfunction

  task automatic drive_rand();
    in_valid   = ($urandom_range(0, 9) < 8);
    in_ra1     = pick_reg();
    in_ra2     = pick_reg();
    in_use1    = ($urandom_range(0, 3) != 0);
    in_use2    = ($urandom_range(0, 3) != 0);
    in_rd      = pick_reg();
    in_we      = ($urandom_range(0, 3) != 0);
    in_is_load = ($urandom_range(0, 2) == 0);
    in_imm     = $urandom;
    in_ctrl    = 12'($urandom);
    RD1        = $urandom;
    RD2        = $urandom;
    exm_rd     = pick_reg();
    exm_we     = ($urandom_range(0, 2) == 0);
    exm_res    = $urandom;
    mwb_rd     = pick_reg();
    mwb_we     = ($urandom_range(0, 2) == 0);
    mwb_res    = $urandom;
    flush      = ($urandom_range(0, 19) == 0);
    out_ready  = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    clear_inputs();
    RST_N = 1'b0;
    m = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_op1", out_op1, 32'd0);
    chk("rst_out_ctrl", {20'd0, out_ctrl}, 32'd0);
    RST_N = 1'b1;

    // No hazard: ADD r1, r2, r3
    @(negedge CLK);
    in_valid = 1'b1; in_ra1 = 4'd2; in_ra2 = 4'd3; in_use1 = 1'b1; in_use2 = 1'b1;
    in_rd = 4'd1; in_we = 1'b1; RD1 = 32'd5; RD2 = 32'd7;
    step();
    chk("t1_op1", out_op1, 32'd5);
    chk("t1_op2", out_op2, 32'd7);

    // EX/MEM forward, then EX/MEM beats MEM/WB
    in_rd = 4'd6; in_use2 = 1'b0;
    exm_rd = 4'd2; exm_we = 1'b1; exm_res = 32'hAA;
    step();
    mwb_rd = 4'd2; mwb_we = 1'b1; mwb_res = 32'hBB;
    step();
`ifdef OPERAND_FWD_EN
    chk("t2_prio", out_op1, 32'hAA);
`else
    chk("t2_stall", {31'd0, in_ready}, 32'd0);
    exm_we = 1'b0; mwb_we = 1'b0;
    step();
    chk("t2_rf", out_op1, 32'd5);
`endif

    // Load-use on r4
    exm_we = 1'b0; mwb_we = 1'b0;
    in_ra1 = 4'd0; in_use1 = 1'b0; in_rd = 4'd4; in_is_load = 1'b1;
    step();
    in_ra1 = 4'd4; in_use1 = 1'b1; in_rd = 4'd7; in_is_load = 1'b0; RD1 = 32'd9;
    #1;
    chk("t3_stall", {31'd0, in_ready}, 32'd0);
    step();
    mwb_rd = 4'd4; mwb_we = 1'b1; mwb_res = 32'h44;
    step();
`ifdef OPERAND_FWD_EN
    chk("t3_fwd", out_op1, 32'h44);
`endif

    // R15 is never forwarded
    mwb_we = 1'b0;
    in_ra1 = 4'd15; exm_rd = 4'd15; exm_we = 1'b1; exm_res = 32'hDEAD; RD1 = 32'h100;
    step();
    chk("t4_r15", out_op1, 32'h100);

    // Backpressure for three cycles, then flush while still stalled downstream
    exm_we = 1'b0; in_ra1 = 4'd1; in_use1 = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_imm = $urandom;
      RD2 = $urandom;
      step();
    end
    flush = 1'b1;
    step();
    chk("t5_flush", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; out_ready = 1'b1;

    // Reset in the stall cycle after a load-use bubble
    in_rd = 4'd4; in_is_load = 1'b1; in_we = 1'b1; in_use1 = 1'b0;
    step();
    in_ra1 = 4'd4; in_use1 = 1'b1; in_rd = 4'd5; in_is_load = 1'b0;
    step();
    RST_N = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_ready", {31'd0, in_ready}, 32'd0);
    m = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    clear_inputs();
    step();

    for (int i = 0; i < 600; i++) begin
      drive_rand();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
